phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
Circular FIFO of free physical register tags for the rename stage of the OoO MIPS core.
- Rename pops one tag per cycle to allocate a destination.
- Commit pushes up to ENQ_WIDTH retired "old" tags per cycle.
- Head pointer is checkpointed per branch column and restored on mispredict.
- Generalises the fixed 64-phys-reg / 4-column setup to parametrised register count, free width and checkpoint count.

Parameters:
- NUM_PHYS_REGS, 64, total physical registers; power of 2.
- NUM_ARCH_REGS, 32, architectural registers; tags 0..NUM_ARCH_REGS-1 are mapped at reset.
- ENQ_WIDTH, 2, commit-side free ports per cycle; range 1..4.
- CHECKPOINT_COLUMNS, 4, number of saved head pointers.
- Derived: FREE_DEPTH = NUM_PHYS_REGS-NUM_ARCH_REGS; PTR_W = $clog2(FREE_DEPTH)+1 (extra wrap bit).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- deq_valid  in  1  rename requests a tag this cycle.
- deq_ready  out  1  tag available = !empty && !restore_valid.
- deq_tag  out  PHYS_REG_WIDTH  tag at head; combinational, show-ahead.
- enq_valid  in  ENQ_WIDTH  per-port free request.
- enq_tag  in  ENQ_WIDTH*PHYS_REG_WIDTH  tags to free; port i at bits [i*W +: W].
- save_valid  in  1  checkpoint head into save_column.
- save_column  in  LOG_CHECKPOINT_COLUMNS  target column.
- restore_valid  in  1  mispredict: restore head from restore_column.
- restore_column  in  LOG_CHECKPOINT_COLUMNS  source column.
- free_count  out  PTR_W  number of free entries, 0..FREE_DEPTH.
- empty  out  1  free_count==0.
- overflow_err  out  1  sticky error flag.

Behaviour:
Reset (async, nRST low):
- entry[i] = NUM_ARCH_REGS+i; head=0; tail=FREE_DEPTH (wrap bit set).
- free_count=FREE_DEPTH; empty=0; overflow_err=0; all checkpoints=0.
- Reset mid-operation discards all state immediately, including checkpoints.

Dequeue:
- Zero-latency read of entry[head].
- On deq_valid && deq_ready: head <= head+1 at the clock edge.
- deq_valid while !deq_ready has no effect.

Enqueue:
- Valid ports compact in port order: port i writes to tail + popcount(enq_valid[i-1:0]).
- tail += popcount(enq_valid).
- Writes land at the edge; a tag freed in cycle N is poppable in N+1, never the same cycle.

Count and pointer arithmetic:
- free_count = tail-head, modulo 2^PTR_W.
- Index = ptr[PTR_W-2:0]; wrap bit disambiguates full from empty.

Overflow:
- Enqueue that would make free_count > FREE_DEPTH sets overflow_err (sticky until reset).
- The excess writes are dropped and tail saturates.
- Debug aid only; a correct core never triggers it.

Save:
- column[save_column] <= head after this cycle's dequeue (head+1 if a pop fires), so a branch's own allocation is kept.

Restore:
- head <= column[restore_column]; same-cycle dequeue is ignored (deq_ready is forced 0).
- Same-cycle enqueues still apply; commits are older than the branch.
- Restore beats save in the same cycle; save is dropped.
- Restored slots are never overwritten: all tags are distinct, so free + speculatively allocated ≤ FREE_DEPTH.

Simultaneous pop and push:
- Legal when full or empty.
- When empty, deq_ready=0 and the push lands.
- When full, the pop frees a slot, so a push of ≤1 does not overflow.

Decomposition:
- Add to core_types_pkg: FREE_DEPTH, LOG_FREE_DEPTH, free_list_ptr_t (LOG_FREE_DEPTH+1 bits).
- Reuse existing phys_reg_tag_t and checkpoint_column_t.
- One sub-module, free_list_enq_compactor: combinational popcount/prefix offsets for the ENQ_WIDTH ports.
- Pointers, storage and checkpoint array stay in the top module.

Test Plan:
- Reset, then pop 32 consecutive cycles → deq_tag 32,33,…,63; then empty=1, deq_ready=0, free_count=0.
- From empty, enq_valid=2'b10 with tag 7, then 2'b11 with tags 5,9 → subsequent pops return 7,5,9; free_count 1→3.
- Pop tags 32,33; save column 2 with a same-cycle pop (head→3); pop 3 more; restore column 2 → next deq_tag=35, free_count=29.
- restore_valid with deq_valid and enq_valid=2'b01 (tag 40) in the same cycle → head restored, no pop, free_count +1.
- At reset (full), enq_valid=2'b01 → overflow_err=1 and stays set; free_count stays 32.
- Assert nRST mid-stream after a save → all entries, pointers and checkpoints back to reset values within the same cycle.

Source files
------------

// File: rtl/core_types_pkg.sv
// Shared core-wide types and constants used by the rename-stage free list.
package core_types_pkg;

    localparam int unsigned CORE_PHYS_REGS    = 64;
    localparam int unsigned CORE_ARCH_REGS    = 32;
    localparam int unsigned CORE_ENQ_WIDTH    = 2;
    localparam int unsigned CORE_CKPT_COLUMNS = 4;

    localparam int unsigned PHYS_REG_WIDTH         = $clog2(CORE_PHYS_REGS);
    localparam int unsigned LOG_CHECKPOINT_COLUMNS = $clog2(CORE_CKPT_COLUMNS);
    localparam int unsigned FREE_DEPTH             = CORE_PHYS_REGS - CORE_ARCH_REGS;
    localparam int unsigned LOG_FREE_DEPTH         = $clog2(FREE_DEPTH);

    typedef logic [PHYS_REG_WIDTH-1:0]         phys_reg_tag_t;
    typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
    typedef logic [LOG_FREE_DEPTH:0]           free_list_ptr_t;

endpackage

// File: rtl/free_list_enq_compactor.sv
// Prefix popcount over the commit-side free ports: each valid port's slot offset from tail.
module free_list_enq_compactor #(
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned CNT_W     = $clog2(ENQ_WIDTH + 1)
) (
    input  logic [ENQ_WIDTH-1:0]       i_enq_valid,
    output logic [ENQ_WIDTH*CNT_W-1:0] o_offset,
    output logic [CNT_W-1:0]           o_count
);

    logic [CNT_W-1:0] w_acc;

    always_comb begin
        w_acc    = '0;
        o_offset = '0;
        for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
            o_offset[i*CNT_W +: CNT_W] = w_acc;
            w_acc = w_acc + CNT_W'(i_enq_valid[i]);
        end
        o_count = w_acc;
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with per-branch head checkpoints.
module phys_reg_free_list
    import core_types_pkg::*;
#(
    parameter  int unsigned NUM_PHYS_REGS      = CORE_PHYS_REGS,
    parameter  int unsigned NUM_ARCH_REGS      = CORE_ARCH_REGS,
    parameter  int unsigned ENQ_WIDTH          = CORE_ENQ_WIDTH,
    parameter  int unsigned CHECKPOINT_COLUMNS = CORE_CKPT_COLUMNS,
    localparam int unsigned TAG_W = $clog2(NUM_PHYS_REGS),
    localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned PTR_W = IDX_W + 1,
    localparam int unsigned COL_W = (CHECKPOINT_COLUMNS > 1) ? $clog2(CHECKPOINT_COLUMNS) : 1,
    localparam int unsigned CNT_W = $clog2(ENQ_WIDTH + 1)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       deq_valid,
    output logic                       deq_ready,
    output logic [TAG_W-1:0]           deq_tag,
    input  logic [ENQ_WIDTH-1:0]       enq_valid,
    input  logic [ENQ_WIDTH*TAG_W-1:0] enq_tag,
    input  logic                       save_valid,
    input  logic [COL_W-1:0]           save_column,
    input  logic                       restore_valid,
    input  logic [COL_W-1:0]           restore_column,
    output logic [PTR_W-1:0]           free_count,
    output logic                       empty,
    output logic                       overflow_err
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [TAG_W-1:0] r_entry [DEPTH];
    logic [PTR_W-1:0] r_ckpt  [CHECKPOINT_COLUMNS];
    logic             r_overflow;

    logic [ENQ_WIDTH*CNT_W-1:0] w_offset;
    logic [CNT_W-1:0]           w_enq_cnt;
    logic                       w_pop;
    logic [PTR_W-1:0]           w_head_deq;
    logic [PTR_W-1:0]           w_head_next;
    logic [PTR_W-1:0]           w_occ;
    logic [PTR_W-1:0]           w_space;
    logic [PTR_W-1:0]           w_tail_next;
    logic                       w_overflow;
    logic [ENQ_WIDTH-1:0]       w_wr_en;
    logic [IDX_W-1:0]           w_wr_idx [ENQ_WIDTH];

    free_list_enq_compactor #(
        .ENQ_WIDTH (ENQ_WIDTH),
        .CNT_W     (CNT_W)
    ) u_compactor (
        .i_enq_valid (enq_valid),
        .o_offset    (w_offset),
        .o_count     (w_enq_cnt)
    );

    assign free_count   = r_tail - r_head;
    assign empty        = (free_count == '0);
    assign deq_ready    = !empty && !restore_valid;
    assign deq_tag      = r_entry[r_head[IDX_W-1:0]];
    assign overflow_err = r_overflow;

    // Free space is judged against the post-pop/post-restore head so a pop frees a slot this cycle.
    always_comb begin
        w_wr_en     = '0;
        w_pop       = deq_valid && deq_ready;
        w_head_deq  = r_head + PTR_W'(w_pop);
        w_head_next = restore_valid ? r_ckpt[restore_column] : w_head_deq;
        w_occ       = r_tail - w_head_next;
        w_space     = (w_occ >= PTR_W'(DEPTH)) ? '0 : PTR_W'(DEPTH) - w_occ;
        w_overflow  = PTR_W'(w_enq_cnt) > w_space;
        w_tail_next = r_tail + (w_overflow ? w_space : PTR_W'(w_enq_cnt));
        for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
            w_wr_en[i]  = enq_valid[i] && (PTR_W'(w_offset[i*CNT_W +: CNT_W]) < w_space);
            w_wr_idx[i] = IDX_W'(r_tail + PTR_W'(w_offset[i*CNT_W +: CNT_W]));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_head     <= '0;
            r_tail     <= PTR_W'(DEPTH);
            r_overflow <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_entry[i] <= TAG_W'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < int'(CHECKPOINT_COLUMNS); c++) begin
                r_ckpt[c] <= '0;
            end
        end else begin
            r_head <= w_head_next;
            r_tail <= w_tail_next;
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end
            // A mispredict squashes any checkpoint taken in the same cycle.
            if (save_valid && !restore_valid) begin
                r_ckpt[save_column] <= w_head_deq;
            end
            for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
                if (w_wr_en[i]) begin
                    r_entry[w_wr_idx[i]] <= enq_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Vector/scoreboard bench for phys_reg_free_list in its default 64/32/2/4 configuration.
module tb_phys_reg_free_list;
    import core_types_pkg::*;

    localparam int unsigned TW = $bits(phys_reg_tag_t);
    localparam int unsigned PW = $bits(free_list_ptr_t);
    localparam int unsigned CW = $bits(checkpoint_column_t);

    logic               CLK = 1'b0;
    logic               nRST;
    logic               deq_valid;
    logic               deq_ready;
    phys_reg_tag_t      deq_tag;
    logic [1:0]         enq_valid;
    logic [2*TW-1:0]    enq_tag;
    logic               save_valid;
    checkpoint_column_t save_column;
    logic               restore_valid;
    checkpoint_column_t restore_column;
    free_list_ptr_t     free_count;
    logic               empty;
    logic               overflow_err;

    typedef struct {
        logic               deq;
        logic [1:0]         enq;
        phys_reg_tag_t      t0;
        phys_reg_tag_t      t1;
        logic               sv;
        checkpoint_column_t sc;
        logic               rv;
        checkpoint_column_t rc;
        logic               exp_ready;
        phys_reg_tag_t      exp_tag;
        free_list_ptr_t     exp_cnt;
        logic               exp_ovf;
    } vec_t;

    vec_t          tbl[$];
    phys_reg_tag_t sb_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    phys_reg_free_list u_dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_tag        (deq_tag),
        .enq_valid      (enq_valid),
        .enq_tag        (enq_tag),
        .save_valid     (save_valid),
        .save_column    (save_column),
        .restore_valid  (restore_valid),
        .restore_column (restore_column),
        .free_count     (free_count),
        .empty          (empty),
        .overflow_err   (overflow_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mv(input int deq, input int enq, input int t0, input int t1,
                                input int sv, input int sc, input int rv, input int rc,
                                input int er, input int et, input int ec, input int eo);
        vec_t v;
        v.deq       = 1'(deq);
        v.enq       = 2'(enq);
        v.t0        = TW'(t0);
        v.t1        = TW'(t1);
        v.sv        = 1'(sv);
        v.sc        = CW'(sc);
        v.rv        = 1'(rv);
        v.rc        = CW'(rc);
        v.exp_ready = 1'(er);
        v.exp_tag   = TW'(et);
        v.exp_cnt   = PW'(ec);
        v.exp_ovf   = 1'(eo);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle();
        deq_valid      = 1'b0;
        enq_valid      = '0;
        enq_tag        = '0;
        save_valid     = 1'b0;
        save_column    = '0;
        restore_valid  = 1'b0;
        restore_column = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        sb_q.delete();
        tick();
        nRST = 1'b1;
    endtask

    // Drive one cycle, check outputs before the edge, then clock it.
    task automatic apply_vec(input vec_t v, input string name);
        phys_reg_tag_t exp_t;
        deq_valid      = v.deq;
        enq_valid      = v.enq;
        enq_tag        = {v.t1, v.t0};
        save_valid     = v.sv;
        save_column    = v.sc;
        restore_valid  = v.rv;
        restore_column = v.rc;
        if (v.exp_ready) sb_q.push_back(v.exp_tag);
        #2;
        chk({name, " deq_ready"}, 32'(deq_ready), 32'(v.exp_ready));
        chk({name, " free_count"}, 32'(free_count), 32'(v.exp_cnt));
        chk({name, " empty"}, 32'(empty), 32'(v.exp_cnt == '0));
        chk({name, " overflow_err"}, 32'(overflow_err), 32'(v.exp_ovf));
        if (sb_q.size() > 0) begin
            exp_t = sb_q.pop_front();
            chk({name, " deq_tag"}, 32'(deq_tag), 32'(exp_t));
        end
        tick();
    endtask

    task automatic run_table(input string phase);
        for (int i = 0; i < tbl.size(); i++) begin
            apply_vec(tbl[i], $sformatf("%s[%0d]", phase, i));
        end
        tbl.delete();
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset free_count", 32'(free_count), 32'd32);
        chk("reset empty", 32'(empty), 32'd0);
        chk("reset deq_ready", 32'(deq_ready), 32'd1);
        chk("reset deq_tag", 32'(deq_tag), 32'd32);
        chk("reset overflow_err", 32'(overflow_err), 32'd0);
        nRST = 1'b1;

        // Drain all 32 free tags, then refill from empty with compacted ports.
        for (int i = 0; i < 32; i++) tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32 + i, 32 - i, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mv(1, 2, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mv(0, 3, 5, 9, 0, 0, 0, 0, 1, 7, 1, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 3, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 5, 2, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table("drain_refill");

        // Checkpoint/restore, restore-vs-save priority, pop+push when full, overflow drop.
        do_reset();
        tbl.push_back(mv(1, 0, 0, 0, 1, 0, 0, 0, 1, 32, 32, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 33, 31, 0));
        tbl.push_back(mv(1, 0, 0, 0, 1, 2, 0, 0, 1, 34, 30, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 35, 29, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 36, 28, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 37, 27, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 26, 0));
        tbl.push_back(mv(0, 0, 0, 0, 1, 1, 0, 0, 1, 35, 29, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 35, 29, 0));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 36, 28, 0));
        tbl.push_back(mv(1, 1, 40, 0, 1, 0, 1, 1, 0, 0, 27, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 35, 30, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 30, 0));
        tbl.push_back(mv(1, 1, 50, 0, 0, 0, 0, 0, 1, 33, 32, 0));
        tbl.push_back(mv(0, 1, 51, 0, 0, 0, 0, 0, 1, 34, 32, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 34, 32, 1));
        run_table("ckpt");

        // Overflow from the reset (full) state is sticky; then dirty state before async reset.
        do_reset();
        tbl.push_back(mv(0, 1, 3, 0, 0, 0, 0, 0, 1, 32, 32, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 1));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 1));
        tbl.push_back(mv(1, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 1));
        tbl.push_back(mv(1, 1, 3, 0, 1, 3, 0, 0, 1, 33, 31, 1));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 34, 31, 1));
        run_table("ovf");

        // Asynchronous reset between edges must take effect immediately.
        idle();
        sb_q.delete();
        #2;
        nRST = 1'b0;
        #1;
        chk("async_rst free_count", 32'(free_count), 32'd32);
        chk("async_rst deq_tag", 32'(deq_tag), 32'd32);
        chk("async_rst overflow_err", 32'(overflow_err), 32'd0);
        chk("async_rst empty", 32'(empty), 32'd0);
        chk("async_rst deq_ready", 32'(deq_ready), 32'd1);
        #1;
        nRST = 1'b1;
        tick();
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32, 0));
        tbl.push_back(mv(0, 0, 0, 0, 0, 0, 0, 0, 1, 32, 32, 0));
        run_table("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
